// File: rtl/ee354_project_control_if.sv
// Signal bundle between the Snake game controller and its surroundings.
// master drives the button, collision and length inputs; slave is the controller.
interface ee354_project_control_if;
  logic       Start;
  logic       Ack;
  logic       Btn_Up;
  logic       Btn_Down;
  logic       Btn_Left;
  logic       Btn_Right;
  logic       Collision;
  logic [7:0] Length;
  logic       q_I;
  logic       q_Run;
  logic       q_Win;
  logic       q_Lose;
  logic       Speed_Clk;
  logic [1:0] In_Dirn;
  logic       SCEN;
  logic       Game_Reset;
  logic [7:0] Score;

  modport master (
    output Start, Ack, Btn_Up, Btn_Down, Btn_Left, Btn_Right, Collision, Length,
    input  q_I, q_Run, q_Win, q_Lose, Speed_Clk, In_Dirn, SCEN, Game_Reset, Score
  );

  modport slave (
    input  Start, Ack, Btn_Up, Btn_Down, Btn_Left, Btn_Right, Collision, Length,
    output q_I, q_Run, q_Win, q_Lose, Speed_Clk, In_Dirn, SCEN, Game_Reset, Score
  );
endinterface

// File: rtl/ee354_project_control.sv
// Snake game controller: INIT/RUN/WIN/LOSE state, speed-scaled move strobe,
// button-to-direction conversion with reverse rejection, and score tracking.
module ee354_project_control #(
  parameter logic [31:0] TICK_BASE  = 32'd25_000_000,
  parameter logic [31:0] TICK_STEP  = 32'd500_000,
  parameter logic [31:0] TICK_MIN   = 32'd5_000_000,
  parameter logic [7:0]  WIN_LENGTH = 8'd50
) (
  input logic                    Clk,
  input logic                    Reset,
  ee354_project_control_if.slave bus
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_t;

  localparam logic [31:0] PERIOD_SPAN = TICK_BASE - TICK_MIN;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_count;
  logic [31:0] r_period;
  logic        r_speed_clk;
  logic [1:0]  r_in_dirn;
  logic [1:0]  r_head_dirn;
  logic [1:0]  r_move_dirn;
  logic        r_scen;
  logic        r_game_reset;
  logic [7:0]  r_score;

  logic        w_run_entry;
  logic        w_run_stay;
  logic        w_press;
  logic [1:0]  w_code;
  logic        w_accept;
  logic [7:0]  w_len_eff;
  logic [31:0] w_dec;
  logic [31:0] w_next_period;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  if (bus.Start && !r_game_reset) w_next = S_RUN;
      // Collision is checked first so it beats a simultaneous win.
      S_RUN: begin
        if (bus.Collision)                w_next = S_LOSE;
        else if (bus.Length >= WIN_LENGTH) w_next = S_WIN;
      end
      S_WIN:   if (bus.Ack) w_next = S_INIT;
      S_LOSE:  if (bus.Ack) w_next = S_INIT;
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  assign w_run_entry = (r_state != S_RUN) && (w_next == S_RUN);
  assign w_run_stay  = (r_state == S_RUN) && (w_next == S_RUN);

  always_comb begin
    w_press = bus.Btn_Up | bus.Btn_Down | bus.Btn_Left | bus.Btn_Right;
    w_code  = 2'b00;
    if (bus.Btn_Up)         w_code = 2'b00;
    else if (bus.Btn_Down)  w_code = 2'b01;
    else if (bus.Btn_Left)  w_code = 2'b10;
    else if (bus.Btn_Right) w_code = 2'b11;
  end

  // Opposite directions differ only in the LSB of the code.
  assign w_accept = (r_state == S_RUN) && w_press &&
                    (w_code != {r_move_dirn[1], ~r_move_dirn[0]});

  assign w_len_eff     = (bus.Length < 8'd3) ? 8'd3 : bus.Length;
  assign w_dec         = TICK_STEP * {24'd0, w_len_eff - 8'd3};
  assign w_next_period = (w_dec >= PERIOD_SPAN) ? TICK_MIN : (TICK_BASE - w_dec);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count      <= 32'd0;
      r_period     <= TICK_BASE;
      r_speed_clk  <= 1'b0;
      r_in_dirn    <= 2'b00;
      r_head_dirn  <= 2'b00;
      r_move_dirn  <= 2'b00;
      r_scen       <= 1'b0;
      r_game_reset <= 1'b0;
      r_score      <= 8'd0;
    end else begin
      r_game_reset <= ((r_state == S_WIN) || (r_state == S_LOSE)) && bus.Ack;

      // No strobe on the edge that leaves RUN.
      if (w_run_stay && (r_count == r_period - 32'd1)) begin
        r_count     <= 32'd0;
        r_speed_clk <= 1'b1;
      end else begin
        r_count     <= w_run_stay ? (r_count + 32'd1) : 32'd0;
        r_speed_clk <= 1'b0;
      end

      if (w_run_entry)      r_period <= TICK_BASE;
      else if (r_speed_clk) r_period <= w_next_period;

      if (w_run_entry) begin
        r_in_dirn   <= 2'b00;
        r_head_dirn <= 2'b00;
        r_move_dirn <= 2'b00;
        r_scen      <= 1'b0;
      end else begin
        r_scen <= w_accept;
        if (w_accept)    r_in_dirn   <= w_code;
        if (r_scen)      r_head_dirn <= r_in_dirn;
        if (r_speed_clk) r_move_dirn <= r_head_dirn;
      end

      if (r_state == S_RUN)
        r_score <= (bus.Length > 8'd3) ? (bus.Length - 8'd3) : 8'd0;
    end
  end

  assign bus.q_I        = (r_state == S_INIT);
  assign bus.q_Run      = (r_state == S_RUN);
  assign bus.q_Win      = (r_state == S_WIN);
  assign bus.q_Lose     = (r_state == S_LOSE);
  assign bus.Speed_Clk  = r_speed_clk;
  assign bus.In_Dirn    = r_in_dirn;
  assign bus.SCEN       = r_scen;
  assign bus.Game_Reset = r_game_reset;
  assign bus.Score      = r_score;

endmodule

// File: tb/tb_ee354_project_control.sv
// Directed bench for the Snake game controller using small tick parameters.
module tb_ee354_project_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   n;

  always #5 clk = ~clk;

  ee354_project_control_if bus_a ();
  ee354_project_control_if bus_b ();

  ee354_project_control #(
    .TICK_BASE(32'd10), .TICK_STEP(32'd2), .TICK_MIN(32'd4), .WIN_LENGTH(8'd6)
  ) dut_a (.Clk(clk), .Reset(rst), .bus(bus_a));

  ee354_project_control #(
    .TICK_BASE(32'd10), .TICK_STEP(32'd2), .TICK_MIN(32'd4), .WIN_LENGTH(8'd20)
  ) dut_b (.Clk(clk), .Reset(rst), .bus(bus_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycles until the next Speed_Clk; 100 means the strobe never came.
  task automatic wait_pulse(input bit use_b, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!(use_b ? bus_b.Speed_Clk : bus_a.Speed_Clk) && cnt < 100);
  endtask

  // btns = {up, down, left, right}
  task automatic press_a(input logic [3:0] btns);
    {bus_a.Btn_Up, bus_a.Btn_Down, bus_a.Btn_Left, bus_a.Btn_Right} = btns;
    step();
    {bus_a.Btn_Up, bus_a.Btn_Down, bus_a.Btn_Left, bus_a.Btn_Right} = 4'b0000;
  endtask

  function automatic logic [3:0] st_a();
    return {bus_a.q_I, bus_a.q_Run, bus_a.q_Win, bus_a.q_Lose};
  endfunction

  initial begin
    {bus_a.Start, bus_a.Ack, bus_a.Btn_Up, bus_a.Btn_Down, bus_a.Btn_Left,
     bus_a.Btn_Right, bus_a.Collision} = '0;
    {bus_b.Start, bus_b.Ack, bus_b.Btn_Up, bus_b.Btn_Down, bus_b.Btn_Left,
     bus_b.Btn_Right, bus_b.Collision} = '0;
    bus_a.Length = 8'd3;
    bus_b.Length = 8'd3;

    step(); step();
    check("rst_state", st_a(), 4'b1000);
    check("rst_speed", bus_a.Speed_Clk, 0);
    check("rst_scen", bus_a.SCEN, 0);
    check("rst_dirn", bus_a.In_Dirn, 0);
    check("rst_greset", bus_a.Game_Reset, 0);
    check("rst_score", bus_a.Score, 0);
    rst = 1'b0;

    press_a(4'b0010);
    check("init_btn_scen", bus_a.SCEN, 0);

    bus_a.Start = 1'b1; step(); bus_a.Start = 1'b0;
    check("start_run", st_a(), 4'b0100);
    check("start_dirn", bus_a.In_Dirn, 0);
    wait_pulse(0, n); check("pulse_1", n, 10);
    wait_pulse(0, n); check("pulse_2", n, 10);
    wait_pulse(0, n); check("pulse_3", n, 10);
    bus_a.Length = 8'd4;
    wait_pulse(0, n); check("len4_period", n, 8);
    bus_a.Length = 8'd5;
    wait_pulse(0, n); check("len5_period", n, 6);

    press_a(4'b0100);
    check("rev_down_scen", bus_a.SCEN, 0);
    press_a(4'b0010);
    check("left_scen", bus_a.SCEN, 1);
    check("left_dirn", bus_a.In_Dirn, 2);
    press_a(4'b0100);
    check("down_vs_move_scen", bus_a.SCEN, 0);
    check("down_vs_move_dirn", bus_a.In_Dirn, 2);
    check("score_len5", bus_a.Score, 2);
    wait_pulse(0, n); check("pulse_mid", n, 3);

    step();
    press_a(4'b0001);
    check("rev_right_scen", bus_a.SCEN, 0);
    press_a(4'b0100);
    check("down_scen", bus_a.SCEN, 1);
    check("down_dirn", bus_a.In_Dirn, 1);
    press_a(4'b0100);
    check("repress_scen", bus_a.SCEN, 1);
    check("repress_dirn", bus_a.In_Dirn, 1);
    press_a(4'b1001);
    check("prio_scen", bus_a.SCEN, 1);
    check("prio_dirn", bus_a.In_Dirn, 0);
    press_a(4'b0100);
    check("pre_lose_dirn", bus_a.In_Dirn, 1);
    check("pulse_at_lose", bus_a.Speed_Clk, 1);

    bus_a.Collision = 1'b1; bus_a.Length = 8'd6;
    step();
    check("lose_state", st_a(), 4'b0001);
    check("lose_speed", bus_a.Speed_Clk, 0);
    check("lose_score", bus_a.Score, 3);
    bus_a.Collision = 1'b0; bus_a.Length = 8'd2;
    step(); step();
    check("lose_hold", st_a(), 4'b0001);
    check("score_frozen", bus_a.Score, 3);

    bus_a.Ack = 1'b1; step(); bus_a.Ack = 1'b0;
    check("ack_init", st_a(), 4'b1000);
    check("ack_greset", bus_a.Game_Reset, 1);
    bus_a.Start = 1'b1; step(); bus_a.Start = 1'b0;
    check("start_ignored", st_a(), 4'b1000);
    check("greset_one_cycle", bus_a.Game_Reset, 0);

    bus_a.Length = 8'd3;
    bus_a.Start = 1'b1; step(); bus_a.Start = 1'b0;
    check("restart_run", st_a(), 4'b0100);
    check("restart_dirn", bus_a.In_Dirn, 0);
    wait_pulse(0, n); check("restart_pulse", n, 10);
    bus_a.Length = 8'd5;
    repeat (5) step();
    bus_a.Length = 8'd6;
    step();
    check("win_state", st_a(), 4'b0010);
    check("win_speed", bus_a.Speed_Clk, 0);
    check("win_score", bus_a.Score, 3);

    bus_a.Ack = 1'b1; step(); bus_a.Ack = 1'b0;
    step();
    bus_a.Length = 8'd3;
    bus_a.Start = 1'b1; step(); bus_a.Start = 1'b0;
    check("run3_state", st_a(), 4'b0100);
    repeat (4) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_state", st_a(), 4'b1000);
    check("midrst_speed", bus_a.Speed_Clk, 0);
    check("midrst_greset", bus_a.Game_Reset, 0);
    check("midrst_score", bus_a.Score, 0);
    bus_a.Start = 1'b1; step(); bus_a.Start = 1'b0;
    wait_pulse(0, n); check("after_rst_pulse", n, 10);

    bus_b.Start = 1'b1; step(); bus_b.Start = 1'b0;
    check("b_run", bus_b.q_Run, 1);
    wait_pulse(1, n); check("b_pulse_1", n, 10);
    bus_b.Length = 8'd7;
    wait_pulse(1, n); check("b_floor_1", n, 4);
    wait_pulse(1, n); check("b_floor_2", n, 4);
    bus_b.Length = 8'd19;
    wait_pulse(1, n); check("b_floor_big", n, 4);
    check("b_still_run", bus_b.q_Run, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ee354_project_control.md
# ee354_project_control

Top-level game controller for the Snake design. It sits directly upstream of the apple and length/position blocks. It owns the one-hot game state (q_I, q_Run, q_Win, q_Lose) and generates the Speed_Clk move strobe, whose period shrinks as the snake grows. It also converts debounced button pulses into In_Dirn/SCEN, with reverse-direction rejection, and consumes Collision and Length to decide win/lose.

## Interface
- TICK_BASE, 25_000_000: move period in Clk cycles at Length ≤ 3.
- TICK_STEP, 500_000: period reduction per segment above 3.
- TICK_MIN, 5_000_000: period floor.
- WIN_LENGTH, 8'd50: Length at which the game is won.

- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high; all state and outputs are sampled on Clk.
- Start  in  1  single-cycle debounced pulse; starts a game from INIT.
- Ack  in  1  single-cycle debounced pulse; leaves WIN/LOSE.
- Btn_Up, Btn_Down, Btn_Left, Btn_Right  in  1 each  single-cycle debounced pulses.
- Collision  in  1  from length block; sticky until that block is reset.
- Length  in  8  from length block.
- q_I, q_Run, q_Win, q_Lose  out  1 each  one-hot state.
- Speed_Clk  out  1  one-cycle move strobe.
- In_Dirn  out  2  direction code: 00 up, 01 down, 10 left, 11 right.
- SCEN  out  1  one-cycle pulse; In_Dirn holds a new value.
- Game_Reset  out  1  one-cycle pulse; the top level ORs it into the apple/length reset.
- Score  out  8  Length−3, saturating at 0.

## Operation
- States are INIT, RUN, WIN and LOSE, all registered. Reset forces INIT.
- Transitions:
  - INIT→RUN on Start.
  - RUN→LOSE when Collision=1.
  - RUN→WIN when Length ≥ WIN_LENGTH.
  - If both RUN exit conditions hold, LOSE wins.
  - WIN/LOSE→INIT on Ack. Game_Reset is asserted during the first INIT cycle after Ack.
  - Start is ignored in any cycle where Game_Reset=1.
- Tick counter (32-bit):
  - Cleared outside RUN.
  - In RUN it counts 0..Period−1.
  - On the edge where the count equals Period−1, the counter wraps to 0 and Speed_Clk is registered to 1. Otherwise Speed_Clk is registered to 0.
- Period register:
  - Loaded with TICK_BASE on RUN entry.
  - Reloaded on every edge where Speed_Clk=1 with max(TICK_MIN, TICK_BASE − TICK_STEP·(L−3)), where L = max(Length, 3).
  - Computed in 32-bit unsigned arithmetic. If TICK_STEP·(L−3) ≥ TICK_BASE − TICK_MIN, the result is TICK_MIN with no underflow.
  - Period never changes mid-interval.
- Direction handling (RUN only):
  - Priority when several buttons fire in one cycle: Up > Down > Left > Right.
  - Head_Dirn mirrors the length block's latched direction: it loads In_Dirn on every edge where SCEN=1.
  - Move_Dirn loads the pre-edge Head_Dirn on every edge where Speed_Clk=1.
  - A press is accepted unless it is the opposite of Move_Dirn (up↔down, left↔right). Accepted: In_Dirn ← code and SCEN ← 1 on the same edge.
  - Rejected presses, and presses outside RUN, produce no SCEN.
  - Re-pressing the current In_Dirn is accepted (SCEN pulses, value unchanged).
- On RUN entry, In_Dirn, Head_Dirn and Move_Dirn are set to 00.
- Score is registered each cycle in RUN and frozen in WIN/LOSE.

## Timing
- Reset values: q_I=1, q_Run=q_Win=q_Lose=0, Speed_Clk=0, SCEN=0, In_Dirn=00, Game_Reset=0, Score=0, counter=0, Period=TICK_BASE.
- Taking Cycle 0 as the first cycle with q_Run=1, the first Speed_Clk is high in cycle Period. Subsequent pulses come every Period cycles.
- SCEN and In_Dirn change one edge after the sampled button pulse.
- State outputs change one edge after the condition is sampled.
- Speed_Clk is 0 in the first cycle after leaving RUN. The counter restarts at 0 on every RUN entry.
- Reset asserted mid-game returns to the reset values on the next edge, with no Game_Reset pulse.
- Collision arriving in the same cycle as Speed_Clk still transitions to LOSE on that edge.

## Test plan
- Parameters TICK_BASE=10, TICK_STEP=2, TICK_MIN=4, WIN_LENGTH=6. Reset, Start, Length=3 → q_Run=1 next cycle; Speed_Clk pulses at RUN cycles 10, 20, 30; In_Dirn=00.
- Length=4, then Length=5 before successive pulses → intervals of 8, then 6 cycles. With WIN_LENGTH=20 and Length=7 → interval 4 (floor).
- Moving up (Move_Dirn=00): Btn_Down → no SCEN. Btn_Left → SCEN, In_Dirn=10. Then Btn_Down before the next Speed_Clk → rejected.
- Btn_Up and Btn_Right in the same cycle → In_Dirn=00. Any button in INIT → no SCEN.
- Collision=1 with Length=6 in RUN → q_Lose=1 next cycle, Speed_Clk=0, Score=3 held. Ack → q_I=1 with a one-cycle Game_Reset.
- Length reaches 6 → q_Win. Reset asserted mid-RUN → q_I=1, counter=0, Speed_Clk=0 next cycle.
